// File: rtl/mdr_mem_unit.sv
// mdr_mem_unit: memory data register with handshaked, timeout-protected memory read/write.
// Define MDR_PARITY_EN to add even-parity checking of read data (mem_rparity / parity_err).
module mdr_mem_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  MDRin,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic [ADDR_WIDTH-1:0] MAR_addr,
    input  logic                  rd_start,
    input  logic                  wr_start,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
`ifdef MDR_PARITY_EN
    input  logic                  mem_rparity,
    output logic                  parity_err,
`endif
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [DATA_WIDTH-1:0] BusMuxIn_MDR
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state        <= IDLE;
            cnt          <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            BusMuxIn_MDR <= '0;
`ifdef MDR_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_start || wr_start) begin
                        mem_addr    <= MAR_addr;
                        mem_req     <= 1'b1;
                        mem_we      <= !rd_start;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        cnt         <= '0;
                        state       <= rd_start ? READ_WAIT : WRITE_WAIT;
                        if (!rd_start) mem_wdata <= BusMuxIn_MDR;
`ifdef MDR_PARITY_EN
                        parity_err  <= 1'b0;
`endif
                    end else if (MDRin) begin
                        BusMuxIn_MDR <= BusMuxOut;
                    end
                end
                READ_WAIT, WRITE_WAIT: begin
                    // an ack on the timeout edge still completes the transfer normally
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                        if (state == READ_WAIT) begin
                            BusMuxIn_MDR <= mem_rdata;
`ifdef MDR_PARITY_EN
                            parity_err   <= (^mem_rdata) != mem_rparity;
`endif
                        end
                    end else if (cnt == LAST) begin
                        mem_req     <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdr_mem_unit.sv
// tb_mdr_mem_unit: directed, self-checking bench for mdr_mem_unit.
module tb_mdr_mem_unit;
    logic        clock = 1'b0, clear_n = 1'b0, MDRin = 1'b0, rd_start = 1'b0, wr_start = 1'b0, mem_ack = 1'b0;
    logic [31:0] BusMuxOut = '0, mem_rdata = '0;
    logic [8:0]  MAR_addr = '0;
    logic        mem_req, mem_we, busy, done, timeout_err;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, BusMuxIn_MDR;
    int total = 0, bad = 0;
`ifdef MDR_PARITY_EN
    logic mem_rparity = 1'b0, parity_err;
`endif

    mdr_mem_unit dut (
        .clock(clock), .clear_n(clear_n), .MDRin(MDRin), .BusMuxOut(BusMuxOut),
        .MAR_addr(MAR_addr), .rd_start(rd_start), .wr_start(wr_start),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
`ifdef MDR_PARITY_EN
        .mem_rparity(mem_rparity), .parity_err(parity_err),
`endif
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .timeout_err(timeout_err), .BusMuxIn_MDR(BusMuxIn_MDR)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        tick();
        total++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL reset_ctrl got req=%b busy=%b done=%b terr=%b want 0000", mem_req, busy, done, timeout_err); end
        total++; if (BusMuxIn_MDR !== 32'h0) begin bad++; $display("FAIL reset_mdr got=%h want=0", BusMuxIn_MDR); end
        clear_n = 1'b1; MDRin = 1'b1; BusMuxOut = 32'hFF;
        tick();
        MDRin = 1'b0; rd_start = 1'b1; MAR_addr = 9'h011;
        tick();
        rd_start = 1'b0;
        total++; if (mem_req !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL reset_pre_req got req=%b busy=%b want 11", mem_req, busy); end
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        total++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL reset_mid_ctrl got req=%b busy=%b done=%b terr=%b want 0000", mem_req, busy, done, timeout_err); end
        total++; if (BusMuxIn_MDR !== 32'h0 || mem_addr !== 9'h0) begin bad++; $display("FAIL reset_mid_regs got mdr=%h addr=%h want 0 0", BusMuxIn_MDR, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h77;
        tick();
        mem_ack = 1'b0;
        total++; if (BusMuxIn_MDR !== 32'h0 || done !== 1'b0) begin bad++; $display("FAIL idle_ack got mdr=%h done=%b want 0 0", BusMuxIn_MDR, done); end
    endtask

    task automatic test_mdrin();
        MDRin = 1'b1; BusMuxOut = 32'h0000_00A5;
        tick();
        MDRin = 1'b0;
        total++; if (BusMuxIn_MDR !== 32'h0000_00A5) begin bad++; $display("FAIL mdrin_load got=%h want=000000a5", BusMuxIn_MDR); end
        total++; if (mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mdrin_req got req=%b busy=%b want 00", mem_req, busy); end
    endtask

    task automatic test_read();
        rd_start = 1'b1; MAR_addr = 9'h03F;
        tick();
        rd_start = 1'b0; MAR_addr = 9'h1AA;
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL read_start got req=%b we=%b busy=%b done=%b want 1010", mem_req, mem_we, busy, done); end
        total++; if (mem_addr !== 9'h03F) begin bad++; $display("FAIL read_addr got=%h want=03f", mem_addr); end
        tick(); tick();
        total++; if (mem_req !== 1'b1 || BusMuxIn_MDR !== 32'h0000_00A5) begin bad++; $display("FAIL read_wait got req=%b mdr=%h want 1 000000a5", mem_req, BusMuxIn_MDR); end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        total++; if (BusMuxIn_MDR !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_data got=%h want=deadbeef", BusMuxIn_MDR); end
        total++; if (done !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL read_done got done=%b busy=%b req=%b want 100", done, busy, mem_req); end
        tick();
        total++; if (done !== 1'b0 || mem_addr !== 9'h03F) begin bad++; $display("FAIL read_after got done=%b addr=%h want 0 03f", done, mem_addr); end
    endtask

    task automatic test_write();
        MDRin = 1'b1; BusMuxOut = 32'h1234_5678;
        tick();
        MDRin = 1'b0; wr_start = 1'b1; MAR_addr = 9'h100;
        tick();
        wr_start = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL write_start got req=%b we=%b busy=%b want 111", mem_req, mem_we, busy); end
        total++; if (mem_wdata !== 32'h1234_5678 || mem_addr !== 9'h100) begin bad++; $display("FAIL write_latch got wdata=%h addr=%h want 12345678 100", mem_wdata, mem_addr); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_ack = 1'b0;
        total++; if (done !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL write_done got done=%b req=%b we=%b busy=%b want 1000", done, mem_req, mem_we, busy); end
        total++; if (BusMuxIn_MDR !== 32'h1234_5678 || mem_wdata !== 32'h1234_5678) begin bad++; $display("FAIL write_mdr got mdr=%h wdata=%h want 12345678", BusMuxIn_MDR, mem_wdata); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL write_pulse got done=%b want 0", done); end
    endtask

    task automatic test_timeout();
        int early = 0;
        rd_start = 1'b1; MAR_addr = 9'h005;
        tick();
        rd_start = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (mem_req !== 1'b1 || done !== 1'b0) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL timeout_early got early_drops=%0d want 0", early); end
        tick();
        total++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_fire got req=%b busy=%b done=%b terr=%b want 0011", mem_req, busy, done, timeout_err); end
        total++; if (BusMuxIn_MDR !== 32'h1234_5678) begin bad++; $display("FAIL timeout_mdr got=%h want=12345678", BusMuxIn_MDR); end
        tick();
        total++; if (done !== 1'b0 || timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky got done=%b terr=%b want 0 1", done, timeout_err); end
        rd_start = 1'b1; MAR_addr = 9'h006;
        tick();
        rd_start = 1'b0;
        total++; if (timeout_err !== 1'b0 || mem_req !== 1'b1) begin bad++; $display("FAIL timeout_clear got terr=%b req=%b want 0 1", timeout_err, mem_req); end
        for (int i = 1; i < 16; i++) tick();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        total++; if (done !== 1'b1 || timeout_err !== 1'b0 || BusMuxIn_MDR !== 32'h0BAD_F00D) begin bad++; $display("FAIL timeout_edge_ack got done=%b terr=%b mdr=%h want 1 0 0badf00d", done, timeout_err, BusMuxIn_MDR); end
    endtask

    task automatic test_priority();
        rd_start = 1'b1; wr_start = 1'b1; MDRin = 1'b1; BusMuxOut = 32'hCAFE_0000; MAR_addr = 9'h0C0;
        tick();
        rd_start = 1'b0; BusMuxOut = 32'h1111_1111; MAR_addr = 9'h0DD;
        total++; if (mem_we !== 1'b0 || mem_req !== 1'b1 || BusMuxIn_MDR !== 32'h0BAD_F00D) begin bad++; $display("FAIL prio_read got we=%b req=%b mdr=%h want 0 1 0badf00d", mem_we, mem_req, BusMuxIn_MDR); end
        tick();
        total++; if (BusMuxIn_MDR !== 32'h0BAD_F00D || mem_we !== 1'b0 || mem_addr !== 9'h0C0) begin bad++; $display("FAIL prio_busy got mdr=%h we=%b addr=%h want 0badf00d 0 0c0", BusMuxIn_MDR, mem_we, mem_addr); end
        wr_start = 1'b0; MDRin = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
        tick();
        mem_ack = 1'b0;
        total++; if (BusMuxIn_MDR !== 32'h0000_0055 || done !== 1'b1) begin bad++; $display("FAIL prio_done got mdr=%h done=%b want 00000055 1", BusMuxIn_MDR, done); end
        tick();
        total++; if (busy !== 1'b0 || mem_req !== 1'b0 || BusMuxIn_MDR !== 32'h0000_0055) begin bad++; $display("FAIL prio_idle got busy=%b req=%b mdr=%h want 0 0 00000055", busy, mem_req, BusMuxIn_MDR); end
    endtask

    initial begin
        test_reset();
        test_mdrin();
        test_read();
        test_write();
        test_timeout();
        test_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdr_mem_unit.md
Name: mdr_mem_unit

Overview:
- Memory Data Register stage that sits directly upstream of the datapath bus multiplexer.
- Loads its 32-bit value either from the bus or from external memory. It runs the memory read/write handshake using the address held in MAR.
- Drives its held value onto the bus-mux input.
- Replaces the plain MDR register with a handshaked, timeout-protected memory interface.

Parameters:
- DATA_WIDTH, 32, width of the MDR and of the memory data paths
- ADDR_WIDTH, 9, memory word-address width (512-word memory)
- TIMEOUT, 16, wait cycles allowed for mem_ack before a transfer aborts (minimum 2)

Ports:
- clock  in  1  system clock, rising-edge
- clear_n  in  1  synchronous active-low reset
- MDRin  in  1  load MDR from BusMuxOut (IDLE only)
- BusMuxOut  in  DATA_WIDTH  datapath bus value
- MAR_addr  in  ADDR_WIDTH  address from MAR
- rd_start  in  1  begin memory read into MDR
- wr_start  in  1  begin memory write of MDR
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion strobe
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_WIDTH  latched transfer address
- mem_wdata  out  DATA_WIDTH  latched write data
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- timeout_err  out  1  last transfer timed out (sticky)
- BusMuxIn_MDR  out  DATA_WIDTH  MDR contents to the bus mux

Behaviour:
- Reset: a clock edge with clear_n=0 forces all registered outputs and the MDR to 0 and the state to IDLE. This applies in any state, including mid-transfer, where mem_req drops immediately.
- States: IDLE, READ_WAIT, WRITE_WAIT.
- IDLE, rd_start=1: at the edge, mem_addr<=MAR_addr, mem_req<=1, mem_we<=0, busy<=1, timeout_err<=0, wait counter<=0; go to READ_WAIT.
- IDLE, wr_start=1 (rd_start=0): same as a read, but mem_we<=1 and mem_wdata<=the current MDR; go to WRITE_WAIT.
- rd_start and wr_start both high: the read wins and the write is dropped.
- IDLE, MDRin=1, no start: MDR<=BusMuxOut at the edge.
- A start takes precedence over MDRin in the same cycle; MDRin is ignored.
- READ_WAIT, mem_ack=1 at an edge: MDR<=mem_rdata, mem_req<=0, busy<=0, done<=1; go to IDLE.
- WRITE_WAIT, mem_ack=1 at an edge: mem_req<=0, mem_we<=0, busy<=0, done<=1; MDR unchanged; go to IDLE.
- WAIT states without ack: the counter increments each edge. When the counter reaches TIMEOUT-1 with no ack:
  - mem_req<=0, busy<=0, done<=1, timeout_err<=1; go to IDLE.
  - MDR unchanged.
- mem_ack sampled on the same edge the timeout fires counts as an ack; the transfer completes normally.
- done is high for exactly one cycle; it is 0 in every other cycle.
- Minimum latency: start sampled at edge N, req visible after N, ack sampled at N+1, done and the new MDR visible after N+1.
- Ignored inputs:
  - mem_ack in IDLE has no effect.
  - MDRin, rd_start and wr_start are ignored while busy.
- mem_addr and mem_wdata hold their values after a transfer until the next start.
- timeout_err clears only on reset or the next accepted start.
- BusMuxIn_MDR is always the MDR register output, with no combinational path from any input.

Optional Feature:
- Macro MDR_PARITY_EN.
- Defined:
  - Adds input mem_rparity (1 bit) and output parity_err (1 bit, reset 0).
  - On a read ack, parity_err<=(^mem_rdata)!=mem_rparity (even parity), and the MDR is still loaded.
  - parity_err is sticky until reset or the next accepted start.
  - No effect on writes.
- Undefined: the ports are absent and no parity logic is built.

Test Plan:
- Reset with clear_n=0 mid-READ_WAIT → next cycle mem_req=0, busy=0, BusMuxIn_MDR=0, done=0, timeout_err=0.
- IDLE, MDRin=1, BusMuxOut=0x0000_00A5 → after one edge BusMuxIn_MDR=0x0000_00A5, mem_req stays 0.
- rd_start with MAR_addr=0x03F; mem_ack=1 with mem_rdata=0xDEAD_BEEF three cycles later → mem_addr=0x03F, mem_we=0, MDR=0xDEAD_BEEF, done pulses exactly one cycle, busy then 0.
- MDR=0x1234_5678, wr_start with MAR_addr=0x100; ack after 1 cycle → mem_we=1, mem_wdata=0x1234_5678 while req is high; MDR unchanged; done pulses.
- rd_start, never ack, TIMEOUT=16 → req drops after 16 cycles, timeout_err=1, MDR unchanged. Next rd_start clears timeout_err.
- rd_start, wr_start and MDRin asserted together → read transfer only (mem_we=0), MDR not loaded from the bus. MDRin asserted while busy → ignored.
